// File: rtl/universal_register_pkg.sv
// Mode encodings shared by the universal register and its users.
package universal_register_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_SHL  = 3'd2;
    localparam logic [2:0] MODE_SHR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_ROR  = 3'd5;
    localparam logic [2:0] MODE_UP   = 3'd6;
    localparam logic [2:0] MODE_DOWN = 3'd7;

endpackage

// File: rtl/universal_register.sv
// WIDTH-bit storage/shift/count register with sync reset, preset, enable
// and a registered wrap pulse for counter overflow/underflow.
module universal_register
    import universal_register_pkg::*;
#(
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH-1:0]   PRESET_VALUE = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]   RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             preset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] _Q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             wrap
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (preset) begin
            q_d = PRESET_VALUE;
        end else if (en) begin
            unique case (mode)
                MODE_HOLD: q_d = q_q;
                MODE_LOAD: q_d = D;
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_UP: begin
                    q_d    = q_q + 1'b1;
                    wrap_d = (q_q == {WIDTH{1'b1}});
                end
                MODE_DOWN: begin
                    q_d    = q_q - 1'b1;
                    wrap_d = (q_q == '0);
                end
                default: q_d = q_q;
            endcase
        end
    end

    // Reset overrides everything, including a wrap computed this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_q    <= RESET_VALUE;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q      = q_q;
    assign _Q     = ~q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_universal_register.sv
// Directed bench for universal_register; driver queues expected state,
// monitor checks it after each clock edge.
module tb_universal_register;
    import universal_register_pkg::*;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         preset = 1'b0;
    logic         en = 1'b0;
    logic [2:0]   mode = MODE_HOLD;
    logic [W-1:0] D = '0;
    logic         sin_l = 1'b0;
    logic         sin_r = 1'b0;
    logic [W-1:0] Q, _Q;
    logic         sout_l, sout_r, wrap;

    universal_register #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset  (reset),
        .preset (preset),
        .en     (en),
        .mode   (mode),
        .D      (D),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
        .Q      (Q),
        ._Q     (_Q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .wrap   (wrap)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] q;
        logic         w;
        int           step;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int st,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, st, act, exp);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("Q", e.step, Q, e.q);
            chk("_Q", e.step, _Q, ~e.q);
            chk("sout_l", e.step, {{(W-1){1'b0}}, sout_l},
                {{(W-1){1'b0}}, e.q[W-1]});
            chk("sout_r", e.step, {{(W-1){1'b0}}, sout_r},
                {{(W-1){1'b0}}, e.q[0]});
            chk("wrap", e.step, {{(W-1){1'b0}}, wrap},
                {{(W-1){1'b0}}, e.w});
        end
    end

    task automatic drv(input logic r, input logic p, input logic e,
                       input logic [2:0] md, input logic [W-1:0] d,
                       input logic sl, input logic sr,
                       input logic [W-1:0] xq, input logic xw);
        exp_t x;
        @(negedge clock);
        reset  = r;
        preset = p;
        en     = e;
        mode   = md;
        D      = d;
        sin_l  = sl;
        sin_r  = sr;
        step_no++;
        x.q    = xq;
        x.w    = xw;
        x.step = step_no;
        sb.push_back(x);
    endtask

    task automatic op(input logic [2:0] md, input logic [W-1:0] d,
                      input logic sl, input logic sr,
                      input logic [W-1:0] xq, input logic xw);
        drv(1'b0, 1'b0, 1'b1, md, d, sl, sr, xq, xw);
    endtask

    initial begin
        logic [W-1:0] rq [8];
        int budget;
        rq[0] = 8'h03; rq[1] = 8'h06; rq[2] = 8'h0C; rq[3] = 8'h18;
        rq[4] = 8'h30; rq[5] = 8'h60; rq[6] = 8'hC0; rq[7] = 8'h81;

        // reset/preset priority and enable gating
        drv(1, 1, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0);
        drv(1, 1, 0, MODE_HOLD, 8'h00, 0, 0, 8'h00, 0);
        drv(0, 1, 0, MODE_HOLD, 8'h00, 0, 0, 8'hFF, 0);
        drv(0, 0, 0, MODE_LOAD, 8'h12, 0, 0, 8'hFF, 0);

        // load and shift
        op(MODE_LOAD, 8'hA5, 0, 0, 8'hA5, 0);
        op(MODE_SHL,  8'h00, 0, 1'bx, 8'h4A, 0);
        op(MODE_SHR,  8'h00, 1'bx, 1, 8'hA5, 0);
        op(MODE_SHR,  8'h00, 1'bx, 0, 8'h52, 0);

        // rotate, serial inputs undriven
        op(MODE_LOAD, 8'h81, 0, 0, 8'h81, 0);
        op(MODE_ROL,  8'h00, 1'bx, 1'bx, 8'h03, 0);
        op(MODE_ROR,  8'h00, 1'bx, 1'bx, 8'h81, 0);
        op(MODE_ROR,  8'h00, 1'bx, 1'bx, 8'hC0, 0);
        op(MODE_LOAD, 8'h81, 0, 0, 8'h81, 0);
        for (int i = 0; i < 8; i++)
            op(MODE_ROL, 8'h00, 1'bx, 1'bx, rq[i], 0);

        // count up through the wrap
        op(MODE_LOAD, 8'hFE, 0, 0, 8'hFE, 0);
        op(MODE_UP,   8'h00, 0, 0, 8'hFF, 0);
        op(MODE_UP,   8'h00, 0, 0, 8'h00, 1);
        op(MODE_UP,   8'h00, 0, 0, 8'h01, 0);

        // count down and alternate across the boundary
        op(MODE_LOAD, 8'h01, 0, 0, 8'h01, 0);
        op(MODE_DOWN, 8'h00, 0, 0, 8'h00, 0);
        op(MODE_DOWN, 8'h00, 0, 0, 8'hFF, 1);
        op(MODE_LOAD, 8'h00, 0, 0, 8'h00, 0);
        op(MODE_DOWN, 8'h00, 0, 0, 8'hFF, 1);
        op(MODE_UP,   8'h00, 0, 0, 8'h00, 1);
        op(MODE_DOWN, 8'h00, 0, 0, 8'hFF, 1);
        op(MODE_UP,   8'h00, 0, 0, 8'h00, 1);
        drv(0, 0, 0, MODE_UP, 8'h00, 0, 0, 8'h00, 0);

        // interrupts mid-operation
        op(MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0);
        drv(1, 0, 1, MODE_UP, 8'h00, 0, 0, 8'h00, 0);
        op(MODE_LOAD, 8'hFF, 0, 0, 8'hFF, 0);
        drv(0, 1, 1, MODE_UP, 8'h00, 0, 0, 8'hFF, 0);
        op(MODE_LOAD, 8'h0F, 0, 0, 8'h0F, 0);
        op(MODE_SHL,  8'h00, 1, 0, 8'h1F, 0);
        drv(0, 1, 1, MODE_SHL, 8'h00, 1, 0, 8'hFF, 0);
        op(MODE_SHL,  8'h00, 0, 0, 8'hFE, 0);
        op(MODE_HOLD, 8'h00, 0, 0, 8'hFE, 0);

        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clock);
            budget--;
        end
        #2;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
